// File: rtl/ps2_entry_pkg.sv
// Shared definitions for the PS/2 numeric entry controller: scan-code
// constants (set 2), buffer limits and the prefix FSM state type.
package ps2_entry_pkg;

  // Digit make codes, indexed by the BCD value they produce
  localparam logic [7:0] SC_DIGIT_0 = 8'h45;
  localparam logic [7:0] SC_DIGIT_1 = 8'h16;
  localparam logic [7:0] SC_DIGIT_2 = 8'h1E;
  localparam logic [7:0] SC_DIGIT_3 = 8'h26;
  localparam logic [7:0] SC_DIGIT_4 = 8'h25;
  localparam logic [7:0] SC_DIGIT_5 = 8'h2E;
  localparam logic [7:0] SC_DIGIT_6 = 8'h36;
  localparam logic [7:0] SC_DIGIT_7 = 8'h3D;
  localparam logic [7:0] SC_DIGIT_8 = 8'h3E;
  localparam logic [7:0] SC_DIGIT_9 = 8'h46;

  // Prefix bytes and editing keys
  localparam logic [7:0] SC_BREAK     = 8'hF0;
  localparam logic [7:0] SC_EXTENDED  = 8'hE0;
  localparam logic [7:0] SC_BACKSPACE = 8'h66;
  localparam logic [7:0] SC_ENTER     = 8'h5A;
  localparam logic [7:0] SC_ESCAPE    = 8'h76;

  // Entry buffer holds at most this many BCD digits
  localparam logic [2:0] MAX_DIGITS = 3'd4;

  // Where we are inside a multi-byte PS/2 sequence
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_t;

endpackage

// File: rtl/ps2_digit_decode.sv
// Combinational map from a set-2 scan byte to a BCD digit.
// is_digit is low for any byte that is not one of the ten digit keys.
module ps2_digit_decode
  import ps2_entry_pkg::*;
(
  input  logic [7:0] scan_byte,
  output logic       is_digit,
  output logic [3:0] bcd
);

  // Lookup of the ten top-row digit make codes
  always_comb begin
    is_digit = 1'b1;
    bcd      = 4'd0;
    case (scan_byte)
      SC_DIGIT_0: bcd = 4'd0;
      SC_DIGIT_1: bcd = 4'd1;
      SC_DIGIT_2: bcd = 4'd2;
      SC_DIGIT_3: bcd = 4'd3;
      SC_DIGIT_4: bcd = 4'd4;
      SC_DIGIT_5: bcd = 4'd5;
      SC_DIGIT_6: bcd = 4'd6;
      SC_DIGIT_7: bcd = 4'd7;
      SC_DIGIT_8: bcd = 4'd8;
      SC_DIGIT_9: bcd = 4'd9;
      default:    is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_entry_ctrl.sv
// PS/2 numeric entry controller: tracks make/break/extended prefixes,
// suppresses typematic repeats and edits a 4-digit BCD buffer that is
// committed with enter and handed off with an entry_valid/entry_ack pair.
// Optional build macro PS2_ENTRY_TIMEOUT_EN discards a partial prefix
// sequence after TIMEOUT_CYCLES idle cycles.
module ps2_entry_ctrl
  import ps2_entry_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [7:0]  scan_byte,
  input  logic        scan_valid,
  input  logic        entry_ack,
  output logic [15:0] digits,
  output logic [2:0]  digit_count,
  output logic [15:0] entry_data,
  output logic        entry_valid,
  output logic        key_released,
  output logic        overflow
);

  prefix_state_t state;
  prefix_state_t state_next;

  logic       make_event;
  logic       make_ext;
  logic       break_event;
  logic       timeout_hit;
  logic [7:0] held_code;

  logic       is_digit;
  logic [3:0] bcd;

  logic       new_key;
  logic       accept;
  logic       do_digit;
  logic       do_bksp;
  logic       do_esc;
  logic       do_enter;

  ps2_digit_decode u_decode (
    .scan_byte (scan_byte),
    .is_digit  (is_digit),
    .bcd       (bcd)
  );

`ifdef PS2_ENTRY_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] idle_cnt;

  // Count cycles since the last scan byte, saturating at the limit
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      idle_cnt <= '0;
    end else if (scan_valid) begin
      idle_cnt <= '0;
    end else if (idle_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

  // The edge that brings the counter to the limit also drops the prefix
  assign timeout_hit = (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;

  // TIMEOUT_CYCLES only has meaning in the timeout build
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_inert
  end
`endif

  // Prefix state register
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Prefix transitions; a fresh byte always wins over a timeout
  always_comb begin
    state_next = state;
    if (scan_valid) begin
      case (state)
        ST_IDLE: begin
          if (scan_byte == SC_BREAK) begin
            state_next = ST_BRK;
          end else if (scan_byte == SC_EXTENDED) begin
            state_next = ST_EXT;
          end
        end
        ST_EXT: begin
          if (scan_byte == SC_BREAK) begin
            state_next = ST_EXT_BRK;
          end else begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (timeout_hit && (state != ST_IDLE)) begin
      state_next = ST_IDLE;
    end
  end

  // Classify the incoming byte as a make, extended make or break
  always_comb begin
    make_event  = 1'b0;
    make_ext    = 1'b0;
    break_event = 1'b0;
    if (scan_valid) begin
      case (state)
        ST_IDLE: begin
          make_event = (scan_byte != SC_BREAK) && (scan_byte != SC_EXTENDED);
        end
        ST_EXT: begin
          make_event = (scan_byte != SC_BREAK);
          make_ext   = 1'b1;
        end
        default: break_event = 1'b1;
      endcase
    end
  end

  // Key actions: repeats of the held key and anything while an entry is
  // pending are dropped; only keypad enter survives among extended makes
  always_comb begin
    new_key  = make_event && (scan_byte != held_code);
    accept   = new_key && !entry_valid;
    do_digit = accept && !make_ext && is_digit;
    do_bksp  = accept && !make_ext && (scan_byte == SC_BACKSPACE);
    do_esc   = accept && !make_ext && (scan_byte == SC_ESCAPE);
    do_enter = accept && (scan_byte == SC_ENTER) && (digit_count != 3'd0);
  end

  // Remember the key currently held down, forget it when it is released
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      held_code <= 8'h00;
    end else if (make_event) begin
      held_code <= scan_byte;
    end else if (break_event && (scan_byte == held_code)) begin
      held_code <= 8'h00;
    end
  end

  // One-cycle pulse for every completed break sequence
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      key_released <= 1'b0;
    end else begin
      key_released <= break_event;
    end
  end

  // Entry buffer editing: shift in digits, backspace, escape, commit
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      digits      <= 16'h0000;
      digit_count <= 3'd0;
      overflow    <= 1'b0;
    end else if (do_digit) begin
      if (digit_count < MAX_DIGITS) begin
        digits      <= {digits[11:0], bcd};
        digit_count <= digit_count + 3'd1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (do_bksp) begin
      if (digit_count != 3'd0) begin
        digits      <= {4'h0, digits[15:4]};
        digit_count <= digit_count - 3'd1;
      end
    end else if (do_esc || do_enter) begin
      digits      <= 16'h0000;
      digit_count <= 3'd0;
      overflow    <= 1'b0;
    end
  end

  // Committed entry handshake with the consumer
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      entry_data  <= 16'h0000;
      entry_valid <= 1'b0;
    end else if (do_enter) begin
      entry_data  <= digits;
      entry_valid <= 1'b1;
    end else if (entry_ack) begin
      entry_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_entry_ctrl.sv
// Self-checking bench for ps2_entry_ctrl: directed scenarios plus a random
// byte stream compared against a queue-based model of the keypad entry.
module tb_ps2_entry_ctrl;

  localparam int unsigned TB_TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  scan_byte = 8'h00;
  logic        scan_valid = 1'b0;
  logic        entry_ack = 1'b0;
  logic [15:0] digits;
  logic [2:0]  digit_count;
  logic [15:0] entry_data;
  logic        entry_valid;
  logic        key_released;
  logic        overflow;

  int total = 0;
  int bad = 0;

  // Model state: digits as a queue (oldest first), prefix flags, held key
  int          m_q[$];
  bit          m_brk;
  bit          m_ext;
  logic [7:0]  m_held;
  bit          m_kr;
  bit          m_ev;
  bit          m_ovf;
  logic [15:0] m_data;

  ps2_entry_ctrl #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .CLK100MHZ    (clk),
    .CPU_RESETN   (rst_n),
    .scan_byte    (scan_byte),
    .scan_valid   (scan_valid),
    .entry_ack    (entry_ack),
    .digits       (digits),
    .digit_count  (digit_count),
    .entry_data   (entry_data),
    .entry_valid  (entry_valid),
    .key_released (key_released),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  function automatic int digit_of(input logic [7:0] b);
    logic [7:0] codes [10];
    codes = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    for (int i = 0; i < 10; i++) if (codes[i] == b) return i;
    return -1;
  endfunction

  function automatic logic [15:0] pack_q();
    logic [15:0] v = 16'h0;
    foreach (m_q[i]) v = (v << 4) | 16'(m_q[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_brk = 0; m_ext = 0; m_held = 8'h00; m_kr = 0;
    m_ev = 0; m_ovf = 0; m_data = 16'h0;
  endtask

  task automatic model_step(input logic [7:0] b, input bit ack);
    bit was_ev;
    bit ext;
    int d;
    was_ev = m_ev;
    m_kr = 0;
    if (m_brk) begin
      m_brk = 0; m_ext = 0; m_kr = 1;
      if (b == m_held) m_held = 8'h00;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (!m_ext && b == 8'hE0) begin
      m_ext = 1;
    end else begin
      ext = m_ext;
      m_ext = 0;
      if (b != m_held) begin
        m_held = b;
        if (!was_ev) begin
          d = digit_of(b);
          if (b == 8'h5A) begin
            if (m_q.size() > 0) begin
              m_data = pack_q(); m_ev = 1; m_q.delete(); m_ovf = 0;
            end
          end else if (!ext) begin
            if (d >= 0) begin
              if (m_q.size() < 4) m_q.push_back(d); else m_ovf = 1;
            end else if (b == 8'h66) begin
              if (m_q.size() > 0) void'(m_q.pop_back());
            end else if (b == 8'h76) begin
              m_q.delete(); m_ovf = 0;
            end
          end
        end
      end
    end
    if (ack && was_ev) m_ev = 0;
  endtask

  // Drive one scan byte for one clock, return at the following falling edge
  task automatic applyStimulus(input logic [7:0] b, input bit ack);
    @(negedge clk);
    scan_byte = b; scan_valid = 1'b1; entry_ack = ack;
    model_step(b, ack);
    @(negedge clk);
    scan_valid = 1'b0; entry_ack = 1'b0;
  endtask

  task automatic applyAck();
    @(negedge clk);
    entry_ack = 1'b1;
    m_kr = 0;
    m_ev = 0;
    @(negedge clk);
    entry_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    scan_valid = 1'b0; entry_ack = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total += 6;
    if (digits !== 16'h0) begin bad++; $display("[TB] FAIL reset_digits: got %h expected 0000", digits); end
    if (digit_count !== 3'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d expected 0", digit_count); end
    if (entry_data !== 16'h0) begin bad++; $display("[TB] FAIL reset_data: got %h expected 0000", entry_data); end
    if (entry_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", entry_valid); end
    if (key_released !== 1'b0) begin bad++; $display("[TB] FAIL reset_kr: got %b expected 0", key_released); end
    if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_basic_entry();
    logic [7:0] seq [9];
    int pulses = 0;
    seq = '{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'h5A, 8'hF0, 8'h5A};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(seq[i], 1'b0);
      if (key_released === 1'b1) pulses++;
      if (i == 0) begin
        total++;
        if (digits !== 16'h0001) begin bad++; $display("[TB] FAIL basic_first_digit: got %h expected 0001", digits); end
      end
      if (i == 3) begin
        total++;
        if (digits !== 16'h0012) begin bad++; $display("[TB] FAIL basic_second_digit: got %h expected 0012", digits); end
      end
    end
    total += 4;
    if (pulses != 3) begin bad++; $display("[TB] FAIL basic_release_pulses: got %0d expected 3", pulses); end
    if (entry_data !== 16'h0012) begin bad++; $display("[TB] FAIL basic_entry_data: got %h expected 0012", entry_data); end
    if (entry_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_entry_valid: got %b expected 1", entry_valid); end
    if (digit_count !== 3'd0) begin bad++; $display("[TB] FAIL basic_count_cleared: got %0d expected 0", digit_count); end
    applyAck();
    total++;
    if (entry_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_ack: got %b expected 0", entry_valid); end
  endtask

  task automatic test_typematic();
    do_reset();
    for (int i = 0; i < 3; i++) applyStimulus(8'h16, 1'b0);
    total += 2;
    if (digit_count !== 3'd1) begin bad++; $display("[TB] FAIL typematic_count: got %0d expected 1", digit_count); end
    if (digits !== 16'h0001) begin bad++; $display("[TB] FAIL typematic_digits: got %h expected 0001", digits); end
  endtask

  task automatic test_overflow_backspace();
    logic [7:0] keys [5];
    keys = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(keys[i], 1'b0);
      applyStimulus(8'hF0, 1'b0);
      applyStimulus(keys[i], 1'b0);
    end
    total += 3;
    if (digits !== 16'h1234) begin bad++; $display("[TB] FAIL ovf_digits: got %h expected 1234", digits); end
    if (digit_count !== 3'd4) begin bad++; $display("[TB] FAIL ovf_count: got %0d expected 4", digit_count); end
    if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
    applyStimulus(8'h66, 1'b0);
    total += 2;
    if (digits !== 16'h0123) begin bad++; $display("[TB] FAIL bksp_digits: got %h expected 0123", digits); end
    if (digit_count !== 3'd3) begin bad++; $display("[TB] FAIL bksp_count: got %0d expected 3", digit_count); end
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h66, 1'b0);
    applyStimulus(8'h76, 1'b0);
    total += 3;
    if (digits !== 16'h0) begin bad++; $display("[TB] FAIL esc_digits: got %h expected 0000", digits); end
    if (digit_count !== 3'd0) begin bad++; $display("[TB] FAIL esc_count: got %0d expected 0", digit_count); end
    if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL esc_ovf: got %b expected 0", overflow); end
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h76, 1'b0);
    applyStimulus(8'h66, 1'b0);
    total++;
    if (digit_count !== 3'd0) begin bad++; $display("[TB] FAIL bksp_empty: got %0d expected 0", digit_count); end
  endtask

  task automatic test_ack_collision();
    do_reset();
    applyStimulus(8'h16, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h16, 1'b0);
    applyStimulus(8'h5A, 1'b0);
    applyStimulus(8'h26, 1'b1);
    total += 3;
    if (entry_valid !== 1'b0) begin bad++; $display("[TB] FAIL collide_valid: got %b expected 0", entry_valid); end
    if (digit_count !== 3'd0) begin bad++; $display("[TB] FAIL collide_count: got %0d expected 0", digit_count); end
    if (entry_data !== 16'h0001) begin bad++; $display("[TB] FAIL collide_data: got %h expected 0001", entry_data); end
  endtask

  task automatic test_ext_enter();
    int pulses = 0;
    do_reset();
    applyStimulus(8'h3D, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h3D, 1'b0);
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h5A, 1'b0);
    total += 2;
    if (entry_data !== 16'h0007) begin bad++; $display("[TB] FAIL ext_enter_data: got %h expected 0007", entry_data); end
    if (entry_valid !== 1'b1) begin bad++; $display("[TB] FAIL ext_enter_valid: got %b expected 1", entry_valid); end
    applyStimulus(8'hE0, 1'b0);
    if (key_released === 1'b1) pulses++;
    applyStimulus(8'hF0, 1'b0);
    if (key_released === 1'b1) pulses++;
    applyStimulus(8'h5A, 1'b0);
    if (key_released === 1'b1) pulses++;
    total++;
    if (pulses != 1) begin bad++; $display("[TB] FAIL ext_break_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_reset_mid_sequence();
    do_reset();
    applyStimulus(8'h1E, 1'b0);
    applyStimulus(8'h5A, 1'b0);
    applyStimulus(8'h16, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total += 4;
    if (entry_valid !== 1'b0) begin bad++; $display("[TB] FAIL async_valid: got %b expected 0", entry_valid); end
    if (entry_data !== 16'h0) begin bad++; $display("[TB] FAIL async_data: got %h expected 0000", entry_data); end
    if (digits !== 16'h0) begin bad++; $display("[TB] FAIL async_digits: got %h expected 0000", digits); end
    if (digit_count !== 3'd0) begin bad++; $display("[TB] FAIL async_count: got %0d expected 0", digit_count); end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h16, 1'b0);
    total += 2;
    if (digits !== 16'h0001) begin bad++; $display("[TB] FAIL post_reset_make: got %h expected 0001", digits); end
    if (key_released !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_kr: got %b expected 0", key_released); end
  endtask

`ifdef PS2_ENTRY_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    applyStimulus(8'hF0, 1'b0);
    repeat (TB_TIMEOUT) @(posedge clk);
    m_brk = 0;
    applyStimulus(8'h16, 1'b0);
    total += 2;
    if (digits !== 16'h0001) begin bad++; $display("[TB] FAIL timeout_make: got %h expected 0001", digits); end
    if (key_released !== 1'b0) begin bad++; $display("[TB] FAIL timeout_kr: got %b expected 0", key_released); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total += 2;
    if (digits !== 16'h0) begin bad++; $display("[TB] FAIL timeout_rst_digits: got %h expected 0000", digits); end
    if (digit_count !== 3'd0) begin bad++; $display("[TB] FAIL timeout_rst_count: got %0d expected 0", digit_count); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  task automatic test_random();
    logic [7:0] pool [8];
    logic [7:0] b;
    int sel;
    pool = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h3D, 8'h46, 8'h66, 8'h76};
    do_reset();
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 11));
      if (sel == 11) begin
        applyAck();
      end else begin
        case (sel)
          0, 1, 2, 3: b = pool[$urandom_range(0, 5)];
          4:          b = pool[$urandom_range(6, 7)];
          5, 6:       b = 8'hF0;
          7:          b = 8'hE0;
          8:          b = 8'h5A;
          default:    b = 8'($urandom_range(0, 255));
        endcase
        applyStimulus(b, $urandom_range(0, 7) == 0);
      end
      total += 6;
      if (digits !== pack_q()) begin bad++; $display("[TB] FAIL rnd_digits step %0d: got %h expected %h", n, digits, pack_q()); end
      if (digit_count !== 3'(m_q.size())) begin bad++; $display("[TB] FAIL rnd_count step %0d: got %0d expected %0d", n, digit_count, m_q.size()); end
      if (entry_valid !== m_ev) begin bad++; $display("[TB] FAIL rnd_valid step %0d: got %b expected %b", n, entry_valid, m_ev); end
      if (entry_data !== m_data) begin bad++; $display("[TB] FAIL rnd_data step %0d: got %h expected %h", n, entry_data, m_data); end
      if (key_released !== m_kr) begin bad++; $display("[TB] FAIL rnd_kr step %0d: got %b expected %b", n, key_released, m_kr); end
      if (overflow !== m_ovf) begin bad++; $display("[TB] FAIL rnd_ovf step %0d: got %b expected %b", n, overflow, m_ovf); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_entry();
    test_typematic();
    test_overflow_backspace();
    test_ack_collision();
    test_ext_enter();
    test_reset_mid_sequence();
`ifdef PS2_ENTRY_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
